// File: rtl/envelope_detector.sv
// Envelope detector for SC16 I/Q streams.
// Each sample's magnitude is approximated as alpha*max(|I|,|Q|) + beta*min(|I|,|Q|) over
// four pipeline stages. The envelope is then taken from one of three runtime-selected
// post-processing modes: raw, exponential smoothing, or peak-hold with decay.
// Output word is {mag, env}. A single stall enable freezes every stage together, so
// backpressure never drops or duplicates a sample.
module envelope_detector #(
  parameter int         SAMP_WIDTH    = 16,
  parameter int         ALPHA_NUM     = 61,
  parameter int         ALPHA_SHIFT   = 6,
  parameter int         BETA_NUM      = 13,
  parameter int         BETA_SHIFT    = 5,
  parameter logic [7:0] SR_ENV_CONFIG = 8'd130
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [2*SAMP_WIDTH-1:0] i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [2*SAMP_WIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
);

  localparam int SW = SAMP_WIDTH;
  // Products are kept at twice the sample width; coefficients are assumed < 2^SW.
  localparam int PW = 2 * SAMP_WIDTH;

  localparam logic [SW-1:0] ALPHA_C = SW'(ALPHA_NUM);
  localparam logic [SW-1:0] BETA_C  = SW'(BETA_NUM);
  localparam logic [SW-1:0] MAG_MAX = {SW{1'b1}};
  localparam logic [SW-1:0] ZERO_SW = {SW{1'b0}};

  localparam logic [1:0] MODE_EMA  = 2'd1;
  localparam logic [1:0] MODE_PEAK = 2'd2;

  // Absolute value of a two's complement component. The most negative code has no
  // positive counterpart, so it clamps to the largest positive value.
  function automatic logic [SW-1:0] abs_sat(input logic [SW-1:0] x);
    logic [SW-1:0] r;
    if (x == {1'b1, {(SW-1){1'b0}}}) begin
      r = {1'b0, {(SW-1){1'b1}}};
    end else if (x[SW-1]) begin
      r = ~x + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Zero-extended full-width product of a magnitude and a coefficient.
  function automatic logic [PW-1:0] mul_full(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
  endfunction

  // Pipeline enable and configuration
  logic          en_s;
  logic [1:0]    cfg_mode_r;
  logic [3:0]    cfg_k_r;
  logic          cfg_clr_r;

  // Stage registers
  logic          v1_r, v2_r, v3_r;
  logic          last1_r, last2_r, last3_r;
  logic [SW-1:0] abs_i_r, abs_q_r;
  logic [SW-1:0] mx_r, mn_r;
  logic [PW-1:0] pa_r, pb_r;

  // Envelope state and output registers
  logic [SW-1:0] env_r;
  logic [SW-1:0] mag_r, env_out_r;

  // Stage-4 combinational results
  logic [PW:0]          mag_sum_s;
  logic [SW-1:0]        mag_s;
  logic [SW-1:0]        env_next_s;
  logic [SW-1:0]        peak_dec_s;
  logic signed [SW:0]   diff_s;
  logic signed [SW:0]   step_s;
  logic signed [SW:0]   ema_s;
  logic                 unused_s;

  // The whole pipeline advances whenever the output slot is empty or being drained.
  assign en_s     = ~o_tvalid | o_tready;
  assign i_tready = en_s;
  assign o_tdata  = {mag_r, env_out_r};

  // Config bits that have no function, plus the EMA sum's sign bit, which is always
  // zero because the smoothed value stays between env and mag.
  assign unused_s = ^{set_data[31:9], set_data[3:2], ema_s[SW]};

  // Capture the configuration word from the settings bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_mode_r <= 2'd0;
      cfg_k_r    <= 4'd0;
      cfg_clr_r  <= 1'b0;
    end else if (set_stb && (set_addr == SR_ENV_CONFIG)) begin
      cfg_mode_r <= set_data[1:0];
      cfg_k_r    <= set_data[7:4];
      cfg_clr_r  <= set_data[8];
    end else begin
      cfg_mode_r <= cfg_mode_r;
      cfg_k_r    <= cfg_k_r;
      cfg_clr_r  <= cfg_clr_r;
    end
  end

  // S1: take saturated absolute values of I and Q.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      abs_i_r <= ZERO_SW;
      abs_q_r <= ZERO_SW;
    end else if (en_s) begin
      v1_r    <= i_tvalid;
      last1_r <= i_tlast;
      abs_i_r <= abs_sat(i_tdata[PW-1:SW]);
      abs_q_r <= abs_sat(i_tdata[SW-1:0]);
    end else begin
      v1_r    <= v1_r;
      last1_r <= last1_r;
      abs_i_r <= abs_i_r;
      abs_q_r <= abs_q_r;
    end
  end

  // S2: sort the two magnitudes into max and min.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
      mx_r    <= ZERO_SW;
      mn_r    <= ZERO_SW;
    end else if (en_s) begin
      v2_r    <= v1_r;
      last2_r <= last1_r;
      if (abs_i_r >= abs_q_r) begin
        mx_r <= abs_i_r;
        mn_r <= abs_q_r;
      end else begin
        mx_r <= abs_q_r;
        mn_r <= abs_i_r;
      end
    end else begin
      v2_r    <= v2_r;
      last2_r <= last2_r;
      mx_r    <= mx_r;
      mn_r    <= mn_r;
    end
  end

  // S3: scale max by alpha and min by beta numerators at full precision.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3_r    <= 1'b0;
      last3_r <= 1'b0;
      pa_r    <= {PW{1'b0}};
      pb_r    <= {PW{1'b0}};
    end else if (en_s) begin
      v3_r    <= v2_r;
      last3_r <= last2_r;
      pa_r    <= mul_full(mx_r, ALPHA_C);
      pb_r    <= mul_full(mn_r, BETA_C);
    end else begin
      v3_r    <= v3_r;
      last3_r <= last3_r;
      pa_r    <= pa_r;
      pb_r    <= pb_r;
    end
  end

  // S4 combinational: finish the magnitude, then compute the candidate envelope.
  always_comb begin
    mag_sum_s = {1'b0, pa_r >> ALPHA_SHIFT} + {1'b0, pb_r >> BETA_SHIFT};
    if (|mag_sum_s[PW:SW]) begin
      mag_s = MAG_MAX;
    end else begin
      mag_s = mag_sum_s[SW-1:0];
    end
    // Exponential smoothing: signed difference, arithmetic shift rounds toward -inf.
    diff_s     = $signed({1'b0, mag_s}) - $signed({1'b0, env_r});
    step_s     = diff_s >>> cfg_k_r;
    ema_s      = $signed({1'b0, env_r}) + step_s;
    // Peak hold: decay the held value by env/2^k unless the new magnitude is higher.
    peak_dec_s = env_r - (env_r >> cfg_k_r);
    case (cfg_mode_r)
      MODE_EMA: begin
        env_next_s = ema_s[SW-1:0];
      end
      MODE_PEAK: begin
        if (mag_s > peak_dec_s) begin
          env_next_s = mag_s;
        end else begin
          env_next_s = peak_dec_s;
        end
      end
      default: begin
        env_next_s = mag_s;
      end
    endcase
  end

  // Envelope state advances only with real samples. A packet end can clear it so the
  // next packet starts from zero; the tlast sample itself still reports its own result.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_r <= ZERO_SW;
    end else if (en_s && v3_r) begin
      if (cfg_clr_r && last3_r) begin
        env_r <= ZERO_SW;
      end else begin
        env_r <= env_next_s;
      end
    end else begin
      env_r <= env_r;
    end
  end

  // S4 output registers. Data is held through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      mag_r     <= ZERO_SW;
      env_out_r <= ZERO_SW;
    end else if (en_s) begin
      o_tvalid <= v3_r;
      o_tlast  <= v3_r & last3_r;
      if (v3_r) begin
        mag_r     <= mag_s;
        env_out_r <= env_next_s;
      end else begin
        mag_r     <= mag_r;
        env_out_r <= env_out_r;
      end
    end else begin
      o_tvalid  <= o_tvalid;
      o_tlast   <= o_tlast;
      mag_r     <= mag_r;
      env_out_r <= env_out_r;
    end
  end

endmodule

// File: tb/tb_envelope_detector.sv
// Directed bench for envelope_detector: reset state, latency, stall hold, saturation,
// backpressure equivalence, EMA/peak/raw modes, clear-on-last and mid-packet reset.
module tb_envelope_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;

  int passed = 0;
  int total  = 0;

  logic [31:0] out_q[$];
  logic        last_q[$];
  logic [31:0] ref_q[$];
  logic        ref_last_q[$];

  always #5 clk = ~clk;

  envelope_detector dut (
    .clk      (clk),
    .reset    (reset),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  // Record every output handshake; inputs change only shortly after posedge.
  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      out_q.push_back(o_tdata);
      last_q.push_back(o_tlast);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pack(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = i[15:0];
    b = q[15:0];
    return {a, b};
  endfunction

  function automatic logic [31:0] mk(input int m, input int e);
    return pack(m, e);
  endfunction

  function automatic int model_mag(input int i, input int q);
    int ai, aq, mx, mn, s;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    if (ai > 32767) ai = 32767;
    if (aq > 32767) aq = 32767;
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    s  = (61 * mx) / 64 + (13 * mn) / 32;
    if (s > 65535) s = 65535;
    return s;
  endfunction

  task automatic cfg(input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'd130;
    set_data = d;
    step();
    set_stb  = 1'b0;
    set_addr = 8'd0;
    set_data = 32'd0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit rnd);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    while (!done && guard < 200) begin
      if (rnd) o_tready = 1'($urandom_range(0, 1));
      #1;
      done = i_tready;
      step();
      guard++;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain(input int n, input bit rnd);
    int guard;
    guard = 0;
    while (out_q.size() < n && guard < 400) begin
      if (rnd) o_tready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    o_tready = 1'b1;
    check("drain_count", 32'(out_q.size()), 32'(n));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int errs;
    int lerrs;
    int m;

    // Reset state
    repeat (3) step();
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata",  o_tdata,       32'd0);
    check("rst_tlast",  32'(o_tlast),  32'd0);
    check("rst_tready", 32'(i_tready), 32'd1);
    reset = 1'b0;
    step();

    // T1: mode0 magnitude and exact 4-cycle latency
    out_q.delete(); last_q.delete();
    send(pack(3000, 4000), 1'b0, 1'b0);
    step();
    step();
    check("t1_lat3_idle", 32'(o_tvalid), 32'd0);
    step();
    check("t1_lat4_valid", 32'(o_tvalid), 32'd1);
    check("t1_data", o_tdata, mk(5030, 5030));
    step();
    check("t1_bubble", 32'(o_tvalid), 32'd0);

    // Stall: output held, input not ready, single delivery on release
    out_q.delete(); last_q.delete();
    o_tready = 1'b0;
    send(pack(-3000, 4000), 1'b1, 1'b0);
    repeat (6) step();
    check("stall_valid", 32'(o_tvalid), 32'd1);
    check("stall_data",  o_tdata,       mk(5030, 5030));
    check("stall_last",  32'(o_tlast),  32'd1);
    check("stall_tready", 32'(i_tready), 32'd0);
    o_tready = 1'b1;
    drain(1, 1'b0);
    repeat (3) step();
    check("stall_once", 32'(out_q.size()), 32'd1);

    // T2: saturation and zero
    out_q.delete(); last_q.delete();
    send(pack(-32768, -32768), 1'b0, 1'b0);
    send(pack(0, 0), 1'b0, 1'b0);
    send(pack(-32768, 0), 1'b0, 1'b0);
    drain(3, 1'b0);
    check("t2_sat",     out_q[0], mk(44542, 44542));
    check("t2_zero",    out_q[1], mk(0, 0));
    check("t2_sat_one", out_q[2], mk(31231, 31231));

    // T3: ramp with o_tready=1 against the model, then with random backpressure
    out_q.delete(); last_q.delete();
    for (int n = 0; n < 64; n++) send(pack(n * 500 - 16000, 12000 - n * 300), (n == 63), 1'b0);
    drain(64, 1'b0);
    errs = 0;
    lerrs = 0;
    for (int n = 0; n < 64; n++) begin
      m = model_mag(n * 500 - 16000, 12000 - n * 300);
      if (out_q[n] !== mk(m, m)) errs++;
      if (last_q[n] !== (n == 63)) lerrs++;
    end
    check("t3_ramp_model", 32'(errs), 32'd0);
    check("t3_ramp_tlast", 32'(lerrs), 32'd0);
    ref_q = out_q;
    ref_last_q = last_q;
    out_q.delete(); last_q.delete();
    for (int n = 0; n < 64; n++) send(pack(n * 500 - 16000, 12000 - n * 300), (n == 63), 1'b1);
    drain(64, 1'b1);
    errs = 0;
    for (int n = 0; n < 64; n++) begin
      if (out_q[n] !== ref_q[n]) errs++;
      if (last_q[n] !== ref_last_q[n]) errs++;
    end
    check("t3_backpressure", 32'(errs), 32'd0);

    // T4: EMA k=2 from env=0
    pulse_reset();
    cfg(32'h0000_0021);
    out_q.delete(); last_q.delete();
    repeat (4) send(pack(3000, 4000), 1'b0, 1'b0);
    drain(4, 1'b0);
    check("t4_ema0", out_q[0], mk(5030, 1257));
    check("t4_ema1", out_q[1], mk(5030, 2200));
    check("t4_ema2", out_q[2], mk(5030, 2907));
    check("t4_ema3", out_q[3], mk(5030, 3437));

    // T5: peak hold k=4 with decay
    cfg(32'h0000_0042);
    out_q.delete(); last_q.delete();
    send(pack(3000, 4000), 1'b0, 1'b0);
    send(pack(0, 0), 1'b0, 1'b0);
    send(pack(0, 0), 1'b0, 1'b0);
    drain(3, 1'b0);
    check("t5_peak0", out_q[0], mk(5030, 5030));
    check("t5_peak1", out_q[1], mk(0, 4716));
    check("t5_peak2", out_q[2], mk(0, 4422));

    // Mode switch keeps env; negative EMA step floors (-4422>>>2 = -1106)
    cfg(32'h0000_0021);
    out_q.delete(); last_q.delete();
    send(pack(0, 0), 1'b0, 1'b0);
    drain(1, 1'b0);
    check("switch_retain", out_q[0], mk(0, 3316));

    // Mode 3 behaves as raw
    cfg(32'h0000_0043);
    out_q.delete(); last_q.delete();
    send(pack(0, 0), 1'b0, 1'b0);
    drain(1, 1'b0);
    check("mode3_raw", out_q[0], mk(0, 0));

    // T6: clear_on_last with EMA k=2 across two packets
    pulse_reset();
    cfg(32'h0000_0121);
    out_q.delete(); last_q.delete();
    for (int n = 0; n < 8; n++) send(pack(3000, 4000), (n == 7), 1'b0);
    for (int n = 0; n < 4; n++) send(pack(3000, 4000), 1'b0, 1'b0);
    drain(12, 1'b0);
    check("t6_p1_last_env", out_q[7], mk(5030, 4525));
    check("t6_p1_tlast",    32'(last_q[7]), 32'd1);
    check("t6_p2_first",    out_q[8], mk(5030, 1257));
    check("t6_p2_second",   out_q[9], mk(5030, 2200));

    // Reset in the middle of packet 2 with a sample sitting at the output
    out_q.delete(); last_q.delete();
    repeat (5) send(pack(3000, 4000), 1'b0, 1'b0);
    check("t6_pre_rst_valid", 32'(o_tvalid), 32'd1);
    reset = 1'b1;
    step();
    check("t6_rst_tvalid", 32'(o_tvalid), 32'd0);
    check("t6_rst_tdata",  o_tdata,       32'd0);
    check("t6_rst_tready", 32'(i_tready), 32'd1);
    reset = 1'b0;
    repeat (6) step();
    check("t6_discard", 32'(out_q.size()), 32'd1);
    check("t6_continue", out_q[0], mk(5030, 3835));
    out_q.delete(); last_q.delete();
    send(pack(3000, 4000), 1'b0, 1'b0);
    drain(1, 1'b0);
    check("t6_mode0_after_rst", out_q[0], mk(5030, 5030));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
